// File: rtl/sdram_cpfeed.sv
// sdram_cpfeed: source side of the SDRAM controller bulk-copy port.
// A loader streams 16-bit words into a ping-pong buffer of two BlkWords-word blocks.
// Each full block is handed to the controller as one copy burst at consecutive SDRAM
// word addresses, so ROM loading overlaps normal controller traffic.
//
// Ports:
//   clk_i, reset_i     clock and asynchronous active-high reset
//   ce_i               copy-side enable; the send FSM, its counters and cpdin advance only when high
//   start_i            load dst_base_i and clear pointers/pending flags (ignored while busy_o)
//   dst_base_i         SDRAM word address of the first block ([9:1] must be zero)
//   wr_en_i/wr_data_i  loader word write; wr_ready_o says the fill buffer has space
//   flush_i            zero-pad a partially filled block and queue it
//   cpsel_o/cpaddr_o/cpdin_o/cpreq_o   copy port towards the controller
//   cprd_i/cpbusy_i    controller copy strobe and busy
//   busy_o             pending block, copy in flight or non-empty fill buffer
//   done_o             one-cycle pulse when a block's copy completes
module sdram_cpfeed #(
  parameter int unsigned BlkWords   = 512,
  parameter int unsigned GapCycles  = 16,
  parameter int unsigned ReqTimeout = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        start_i,
  input  logic [26:1] dst_base_i,
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ready_o,
  input  logic        flush_i,
  output logic        cpsel_o,
  output logic [26:1] cpaddr_o,
  output logic [15:0] cpdin_o,
  output logic        cpreq_o,
  input  logic        cprd_i,
  input  logic        cpbusy_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned PtrW = $clog2(BlkWords);
  localparam int unsigned GapW = $clog2(GapCycles + 1);
  localparam int unsigned ToW  = $clog2(ReqTimeout + 1);

  typedef enum logic [2:0] {StIdle, StReq, StStream, StDrain, StGap} state_e;

  logic [15:0] mem_q [2*BlkWords];

  // Fill side
  logic [PtrW-1:0] fill_ptr_q, fill_ptr_nxt;
  logic            fill_buf_q;
  logic            padding_q, padding_d;
  logic [26:1]     blk_addr_q;
  logic [26:1]     addr_q [2];
  logic [1:0]      pending_q, pending_d;
  logic            fill_we, fill_last, start_ok;
  logic [15:0]     fill_wdata;

  // Send side
  state_e          state_q, state_d;
  logic            send_buf_q, send_buf_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            full_q, full_d;
  logic            cpsel_q, cpsel_d, cpreq_q, cpreq_d, done_q, done_d;
  logic [26:1]     cpaddr_q, cpaddr_d;
  logic [15:0]     cpdin_q, cpdin_d;
  logic            blk_clr;

  assign wr_ready_o = ~pending_q[fill_buf_q] & ~padding_q;
  assign busy_o     = (|pending_q) | (state_q inside {StReq, StStream, StDrain}) |
                      (fill_ptr_q != '0) | padding_q;
  assign start_ok   = start_i & ~busy_o;

  assign cpsel_o  = cpsel_q;
  assign cpaddr_o = cpaddr_q;
  assign cpdin_o  = cpdin_q;
  assign cpreq_o  = cpreq_q;
  assign done_o   = done_q;

  always_comb begin
    fill_we      = ~start_ok & (padding_q | (wr_en_i & wr_ready_o));
    fill_wdata   = padding_q ? 16'h0000 : wr_data_i;
    fill_last    = fill_we && (fill_ptr_q == PtrW'(BlkWords - 1));
    fill_ptr_nxt = fill_we ? fill_ptr_q + PtrW'(1) : fill_ptr_q;
    // A word written alongside flush lands first; padding only if the block is still partial.
    padding_d    = fill_last ? 1'b0 : (padding_q | (flush_i & (fill_ptr_nxt != '0)));
    pending_d    = pending_q;
    if (fill_last) pending_d[fill_buf_q] = 1'b1;
    // Clear applied last so it wins over a set on the same buffer.
    if (blk_clr) pending_d[send_buf_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) mem_q[{fill_buf_q, fill_ptr_q}] <= fill_wdata;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fill_ptr_q <= '0;
      fill_buf_q <= 1'b0;
      padding_q  <= 1'b0;
      blk_addr_q <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      pending_q  <= 2'b00;
    end else if (start_ok) begin
      fill_ptr_q <= '0;
      fill_buf_q <= 1'b0;
      padding_q  <= 1'b0;
      blk_addr_q <= dst_base_i;
      pending_q  <= 2'b00;
    end else begin
      fill_ptr_q <= fill_ptr_nxt;
      padding_q  <= padding_d;
      pending_q  <= pending_d;
      if (fill_last) begin
        addr_q[fill_buf_q] <= blk_addr_q;
        blk_addr_q         <= blk_addr_q + 26'(BlkWords);
        fill_buf_q         <= ~fill_buf_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    send_buf_d = send_buf_q;
    rd_ptr_d   = rd_ptr_q;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    full_d     = full_q;
    cpsel_d    = cpsel_q;
    cpaddr_d   = cpaddr_q;
    cpdin_d    = cpdin_q;
    cpreq_d    = cpreq_q;
    done_d     = 1'b0;
    blk_clr    = 1'b0;
    if (ce_i) begin
      unique case (state_q)
        StIdle: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GapW'(1);
          end else if (pending_q[send_buf_q]) begin
            state_d  = StReq;
            cpsel_d  = 1'b1;
            cpaddr_d = addr_q[send_buf_q];
            cpreq_d  = 1'b1;
            cpdin_d  = mem_q[{send_buf_q, PtrW'(0)}];
            to_cnt_d = '0;
          end
        end
        StReq: begin
          // First cprd edge is the controller's wait cycle: nothing consumed yet.
          if (cprd_i) begin
            state_d  = StStream;
            cpreq_d  = 1'b0;
            rd_ptr_d = '0;
            full_d   = 1'b0;
          end else if (to_cnt_q == ToW'(ReqTimeout - 1)) begin
            state_d   = StGap;
            cpreq_d   = 1'b0;
            cpsel_d   = 1'b0;
            gap_cnt_d = GapW'(GapCycles);
          end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
          end
        end
        StStream: begin
          if (cprd_i) begin
            cpdin_d  = mem_q[{send_buf_q, rd_ptr_q + PtrW'(1)}];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (rd_ptr_q == PtrW'(BlkWords - 1)) begin
              full_d  = 1'b1;
              state_d = StDrain;
            end
          end else begin
            // Early cprd drop: block stays pending and is resent.
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (!cpbusy_i) begin
            if (full_q) begin
              blk_clr    = 1'b1;
              send_buf_d = ~send_buf_q;
              done_d     = 1'b1;
            end
            cpsel_d   = 1'b0;
            gap_cnt_d = GapW'(GapCycles);
            state_d   = StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) state_d = StIdle;
          else gap_cnt_d = gap_cnt_q - GapW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      send_buf_q <= 1'b0;
      rd_ptr_q   <= '0;
      gap_cnt_q  <= GapW'(GapCycles);
      to_cnt_q   <= '0;
      full_q     <= 1'b0;
      cpsel_q    <= 1'b0;
      cpaddr_q   <= '0;
      cpdin_q    <= '0;
      cpreq_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_buf_q <= start_ok ? 1'b0 : send_buf_d;
      rd_ptr_q   <= rd_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      full_q     <= full_d;
      cpsel_q    <= cpsel_d;
      cpaddr_q   <= cpaddr_d;
      cpdin_q    <= cpdin_d;
      cpreq_q    <= cpreq_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sdram_cpfeed.sv
// Scoreboard bench for sdram_cpfeed: stimulus pushes expected words/addresses into queues,
// a controller model pops and compares words at each consume, a monitor checks requests.
module tb_sdram_cpfeed;

  logic        clk = 1'b0;
  logic        reset, ce, start, wr_en, flush, cprd, cpbusy;
  logic [26:1] dst_base;
  logic [15:0] wr_data;
  logic        wr_ready, cpsel, cpreq, busy, done;
  logic [26:1] cpaddr;
  logic [15:0] cpdin;

  sdram_cpfeed dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .ce_i       (ce),
    .start_i    (start),
    .dst_base_i (dst_base),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .flush_i    (flush),
    .cpsel_o    (cpsel),
    .cpaddr_o   (cpaddr),
    .cpdin_o    (cpdin),
    .cpreq_o    (cpreq),
    .cprd_i     (cprd),
    .cpbusy_i   (cpbusy),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [26:1] addr_q[$];
  int ce_mode = 0;
  int ignore_cyc = 0;
  int consumed = 0;
  int done_cnt = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ce: constant 1, or toggling every cycle; changed just after the active edge.
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ce_mode == 0) ce = 1'b1;
      else ce = ~ce;
    end
  end

  // Controller model: responds to a cpreq rising edge, one wait edge, then 512 consumes.
  initial begin : ctrl
    logic last;
    int   n;
    bit   abort;
    logic [15:0] e;
    last   = 1'b0;
    cprd   = 1'b0;
    cpbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last = 1'b0;
        continue;
      end
      if (!ce) continue;
      if (!(cpreq && !last)) begin
        last = cpreq;
        continue;
      end
      last = 1'b1;
      if (ignore_cyc > 0) begin
        repeat (ignore_cyc) @(negedge clk);
        ignore_cyc = 0;
        last = cpreq;
        if (!cpreq) continue;
      end
      cprd   = 1'b1;
      cpbusy = 1'b1;
      n      = 0;
      abort  = 1'b0;
      forever begin
        if (reset) begin
          abort = 1'b1;
          break;
        end
        if (ce) begin
          n++;
          if (n >= 2) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_word actual=%h required=none", cpdin);
            end else begin
              e = exp_q.pop_front();
              check("cpdin_word", 32'(cpdin), 32'(e));
            end
            consumed++;
          end
        end
        if (n == 513) break;
        @(negedge clk);
      end
      if (!abort) begin
        @(negedge clk);
        cprd = 1'b0;
        repeat (3) @(negedge clk);
      end
      cprd   = 1'b0;
      cpbusy = 1'b0;
      last   = 1'b0;
    end
  end

  // Request monitor: address per request, gap before each request, timeout length, done count.
  initial begin : mon
    logic prev_req;
    int   hi, lo;
    bit   saw_rd;
    prev_req = 1'b0;
    hi = 0;
    lo = 0;
    saw_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        lo = 0;
      end
      if (cpreq && !prev_req) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h required=none", cpaddr);
        end else begin
          check("cpaddr", 32'(cpaddr), 32'(addr_q.pop_front()));
        end
        check("cpreq_gap_ge16", 32'(lo >= 16), 32'd1);
        hi = 0;
        saw_rd = 1'b0;
      end
      if (!cpreq && prev_req) begin
        if (!saw_rd && !reset) check("timeout_len", 32'(hi), 32'd4096);
        lo = 0;
      end
      if (ce) begin
        if (cpreq) begin
          hi++;
          if (cprd) saw_rd = 1'b1;
        end else begin
          lo++;
        end
      end
      prev_req = cpreq;
    end
  end

  task automatic do_start(input logic [26:1] base);
    @(negedge clk);
    start    = 1'b1;
    dst_base = base;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wr_word(input logic [15:0] d, input bit with_flush);
    int t = 0;
    @(negedge clk);
    if (!wr_ready) stalls++;
    while (!wr_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_timeout actual=0 required=1");
    end
    wr_en   = 1'b1;
    wr_data = d;
    flush   = with_flush;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while ((done_cnt < target || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
    check("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_cpsel", 32'(cpsel), 32'd0);
    check("rst_cpaddr", 32'(cpaddr), 32'd0);
    check("rst_cpdin", 32'(cpdin), 32'd0);
    check("rst_cpreq", 32'(cpreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
  endtask

  initial begin : stim
    int c0;
    int t;
    reset    = 1'b1;
    start    = 1'b0;
    wr_en    = 1'b0;
    flush    = 1'b0;
    dst_base = '0;
    wr_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // One block, words 0..511.
    do_start(26'h4000);
    addr_q.push_back(26'h4000);
    stalls = 0;
    for (int i = 0; i < 512; i++) wr_word(16'(i), 1'b0);
    check("t1_stalls", 32'(stalls), 32'd0);
    wait_done(1);

    // Two blocks back to back; a start mid-load must be ignored.
    do_start(26'h4000);
    addr_q.push_back(26'h4000);
    addr_q.push_back(26'h4200);
    stalls = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 100) do_start(26'h7000);
      wr_word(16'(i) ^ 16'h3c00, 1'b0);
    end
    check("t2_stalls", 32'(stalls), 32'd0);
    wait_done(3);

    // Partial block flushed together with its last word, padded with zeros.
    do_start(26'h8000);
    addr_q.push_back(26'h8000);
    wr_word(16'hAAAA, 1'b0);
    wr_word(16'hBBBB, 1'b0);
    wr_word(16'hCCCC, 1'b1);
    for (int i = 0; i < 509; i++) exp_q.push_back(16'h0000);
    wait_done(4);

    // Controller ignores the request: withdraw at timeout, retry, then complete.
    ignore_cyc = 5000;
    do_start(26'h1000);
    addr_q.push_back(26'h1000);
    addr_q.push_back(26'h1000);
    for (int i = 0; i < 512; i++) wr_word(16'(i) ^ 16'h5a5a, 1'b0);
    wait_done(5);

    // ce toggling during the copy.
    ce_mode = 1;
    do_start(26'h2000);
    addr_q.push_back(26'h2000);
    for (int i = 0; i < 512; i++) wr_word(16'(i * 3), 1'b0);
    wait_done(6);
    ce_mode = 0;

    // Reset mid-stream, then a fresh block.
    do_start(26'h3000);
    addr_q.push_back(26'h3000);
    c0 = consumed;
    for (int i = 0; i < 512; i++) wr_word(16'hf000 ^ 16'(i), 1'b0);
    t = 0;
    while (consumed < c0 + 200 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("reached_consume_200", 32'(consumed >= c0 + 200), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    do_start(26'h0C00);
    addr_q.push_back(26'h0C00);
    for (int i = 0; i < 512; i++) wr_word(16'(i) + 16'h0100, 1'b0);
    wait_done(7);

    check("words_left", 32'(exp_q.size()), 32'd0);
    check("reqs_left", 32'(addr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
